pe_link_arbiter: RTL and testbench
==================================

# pe_link_arbiter

Clocked round-robin arbiter sharing one 47-bit network injection link among the three PE packetizers of a PE row. Each PE alternates NUM_PSUMS partial-sum packets (to the adder node) with one filter-forward packet (to the next PE). The block buffers one packet toward the router and checks every packet against that phase protocol. It raises a one-cycle `round_done` pulse when all three PEs finish a full psum+filter round.

## Interface
- PWIDTH, 47, packet width; fields [46] ifm1_filt0, [45:43] dest, [42:40] src, [39:0] data
- NUM_REQ, 3, number of PE requesters (fixed at 3)
- NUM_PSUMS, 3, psum packets per PE before its filter packet
- ADDER_ADDR, 4, required dest of psum packets
- PE_ADDRS, {3'd0,3'd1,3'd3}, src address of requester 2,1,0 (requester i uses PE_ADDRS[3i+2:3i])

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_pkt  in  NUM_REQ*PWIDTH  packet from requester i at [PWIDTH*i +: PWIDTH]
- req_valid  in  NUM_REQ  requester i offers a packet
- req_ready  out  NUM_REQ  one-hot or zero; packet i accepted when req_valid[i]&req_ready[i]
- out_pkt  out  PWIDTH  buffered packet to router
- out_valid  out  1  out_pkt holds a packet
- out_ready  in  1  router accepts; transfer when out_valid&out_ready
- round_done  out  1  one-cycle pulse: all PEs completed a round
- proto_err  out  1  sticky protocol-violation flag
- err_src  out  2  index of the requester causing the first violation

## Operation
- One-entry output register. `can_load` = !out_valid | out_ready.
- Arbitration: rotating pointer `rr` (0..2). Grant goes to the first i with req_valid[i], searching rr, rr+1, rr+2 mod 3. req_ready[grant]=can_load; all other bits are 0. req_ready is combinational from req_valid, rr and out state; it never depends on req_pkt.
- On accept: out_pkt<=req_pkt[grant], out_valid<=1, rr<=(grant+1) mod 3. With no accept and out_ready, out_valid<=0 and out_pkt holds its value.
- Per-requester phase counter cnt[i] (0..NUM_PSUMS) and done[i] flag:
  - cnt[i]<NUM_PSUMS: the packet must have bit46=1, dest=ADDER_ADDR, src=PE_ADDRS[i]. Then cnt[i]++.
  - cnt[i]==NUM_PSUMS: the packet must have bit46=0 and src=PE_ADDRS[i]. Then cnt[i]<=0 and done[i]<=1.
  - The counter advances on the packet's type expectation regardless of violation. A violating packet is still forwarded unchanged.
- Violation: if proto_err==0, then proto_err<=1 and err_src<=i. Later violations do not update err_src. Only reset clears the flag.
- Round completion: when done[] would become 3'b111 (including the cycle the last flag sets), round_done<=1 for one cycle and done[]<=0 in the same edge.
- Reset (any time, asynchronous): in-flight buffered packet dropped; all state cleared.

## Timing
- Reset values: out_valid=0, out_pkt=0, req_ready=0 while rst_n=0, round_done=0, proto_err=0, err_src=0, rr=0, cnt[]=0, done[]=0.
- Latency: accept at edge N gives out_valid=1 after edge N (visible cycle N+1).
- Throughput: 1 packet/cycle with out_ready held high; zero bubbles on back-to-back grants.
- Backpressure: while out_valid&!out_ready, out_pkt and out_valid stay stable, and req_ready=0.
- Simultaneous drain and load in one cycle: the register is replaced with no bubble.
- round_done rises the cycle after the edge that accepted the completing filter packet and lasts exactly one cycle.
- Fairness: any continuously valid requester is granted within 3 accepts.

## Test plan
- Reset mid-traffic: assert rst_n=0 with out_valid=1 -> next cycle out_valid=0, out_pkt=0, req_ready=0, proto_err=0. After release, first grant goes to req 0.
- All three valid, out_ready=1: grants 0,1,2,0,1,2 on consecutive cycles. out_pkt follows with 1-cycle lag and no bubbles.
- Backpressure: out_ready=0 for 4 cycles while req 1 is valid -> out_pkt stable, req_ready=000. On out_ready=1, drain and reload happen in the same cycle.
- Legal round: each PE sends 3 psums (dest 4, src 3/1/0, bit46=1), then 1 filter (bit46=0) -> round_done pulses exactly once, one cycle after the last filter is accepted, and proto_err=0.
- Violations: req 2 sends a filter while cnt=1 -> proto_err=1 and err_src=2, and the packet is still forwarded. A later bad dest from req 0 leaves err_src=2.
- Wrong src: req 1 psum with src=3 -> proto_err=1, err_src=1, and cnt[1] still increments.

Source files
------------

// File: rtl/pe_link_arbiter.sv
// Round-robin arbiter sharing one injection link among three PE packetizers.
// Buffers one packet toward the router and checks each PE's psum/filter phase protocol.
module pe_link_arbiter #(
    parameter int          PWIDTH     = 47,
    parameter int          NUM_REQ    = 3,
    parameter int          NUM_PSUMS  = 3,
    parameter logic [2:0]  ADDER_ADDR = 3'd4,
    parameter logic [8:0]  PE_ADDRS   = {3'd0, 3'd1, 3'd3}
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ*PWIDTH-1:0] req_pkt,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [PWIDTH-1:0]         out_pkt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      round_done,
    output logic                      proto_err,
    output logic [1:0]                err_src
);

    localparam int CW = $clog2(NUM_PSUMS + 1);

    // Handshake rule: a packet moves on any port exactly in the cycle its
    // valid and ready are both high at the rising clock edge.

    logic [PWIDTH-1:0]            out_pkt_q, out_pkt_d;
    logic                         out_valid_q, out_valid_d;
    logic [1:0]                   rr_q, rr_d;
    logic [NUM_REQ-1:0][CW-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0]           done_q, done_d;
    logic                         round_done_q, round_done_d;
    logic                         proto_err_q, proto_err_d;
    logic [1:0]                   err_src_q, err_src_d;

    logic [1:0]          grant;
    logic                found;
    logic [2:0]          idx;
    logic                can_load;
    logic                accept;
    logic [PWIDTH-1:0]   sel_pkt;
    logic [2:0]          exp_src;
    logic                pkt_ok;
    logic [NUM_REQ-1:0]  done_set;
    logic [NUM_REQ-1:0]  done_next;

    // First valid requester searching from the rotating pointer.
    always_comb begin
        grant = 2'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_q} + 3'(k);
            if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = idx[1:0];
            end
        end
    end

    assign can_load  = !out_valid_q || out_ready;
    assign accept    = found && can_load;
    assign req_ready = (accept && rst_n) ? (NUM_REQ'(1) << grant) : '0;
    assign sel_pkt   = req_pkt[int'(grant)*PWIDTH +: PWIDTH];
    assign exp_src   = PE_ADDRS[int'(grant)*3 +: 3];

    always_comb begin
        out_pkt_d    = out_pkt_q;
        out_valid_d  = out_valid_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        proto_err_d  = proto_err_q;
        err_src_d    = err_src_q;
        round_done_d = 1'b0;
        pkt_ok       = 1'b1;
        done_set     = '0;
        if (accept) begin
            out_pkt_d   = sel_pkt;
            out_valid_d = 1'b1;
            rr_d        = (grant == 2'(NUM_REQ - 1)) ? 2'd0 : grant + 2'd1;
            // Counter follows the expected packet type even when the packet violates it.
            if (cnt_q[grant] < CW'(NUM_PSUMS)) begin
                pkt_ok = sel_pkt[PWIDTH-1] && (sel_pkt[PWIDTH-2 -: 3] == ADDER_ADDR)
                         && (sel_pkt[PWIDTH-5 -: 3] == exp_src);
                cnt_d[grant] = cnt_q[grant] + CW'(1);
            end else begin
                pkt_ok = !sel_pkt[PWIDTH-1] && (sel_pkt[PWIDTH-5 -: 3] == exp_src);
                cnt_d[grant]    = '0;
                done_set[grant] = 1'b1;
            end
            if (!pkt_ok && !proto_err_q) begin
                proto_err_d = 1'b1;
                err_src_d   = grant;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        done_next = done_q | done_set;
        if (&done_next) begin
            round_done_d = 1'b1;
            done_d       = '0;
        end else begin
            done_d = done_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pkt_q    <= '0;
            out_valid_q  <= 1'b0;
            rr_q         <= 2'd0;
            cnt_q        <= '0;
            done_q       <= '0;
            round_done_q <= 1'b0;
            proto_err_q  <= 1'b0;
            err_src_q    <= 2'd0;
        end else begin
            out_pkt_q    <= out_pkt_d;
            out_valid_q  <= out_valid_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            round_done_q <= round_done_d;
            proto_err_q  <= proto_err_d;
            err_src_q    <= err_src_d;
        end
    end

    assign out_pkt    = out_pkt_q;
    assign out_valid  = out_valid_q;
    assign round_done = round_done_q;
    assign proto_err  = proto_err_q;
    assign err_src    = err_src_q;

endmodule

// File: tb/tb_pe_link_arbiter.sv
// Bench for pe_link_arbiter: arbitration vector table plus protocol/round sequences,
// with a packet scoreboard on the router side.
module tb_pe_link_arbiter;

    logic          clk;
    logic          rst_n;
    logic [140:0]  req_pkt;
    logic [2:0]    req_valid;
    logic [2:0]    req_ready;
    logic [46:0]   out_pkt;
    logic          out_valid;
    logic          out_ready;
    logic          round_done;
    logic          proto_err;
    logic [1:0]    err_src;

    pe_link_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_pkt(req_pkt), .req_valid(req_valid),
        .req_ready(req_ready), .out_pkt(out_pkt), .out_valid(out_valid),
        .out_ready(out_ready), .round_done(round_done), .proto_err(proto_err),
        .err_src(err_src)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [46:0] exp_q[$];
    logic [46:0] pkt [3];
    logic [46:0] pend_pkt;
    logic [2:0]  cur_exp_rdy;
    bit          mon_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [46:0] mk_pkt(input int i, input bit filt, input int tag);
        logic [31:0] r;
        logic [2:0]  src;
        r = $urandom();
        case (i)
            0:       src = 3'd3;
            1:       src = 3'd1;
            default: src = 3'd0;
        endcase
        return {~filt, (filt ? 3'd1 : 3'd4), src, r, 8'(tag)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [2:0] v, input logic ordy, input logic [2:0] erdy);
        @(posedge clk);
        #1;
        req_valid   = v;
        out_ready   = ordy;
        req_pkt     = {pkt[2], pkt[1], pkt[0]};
        cur_exp_rdy = erdy;
        case (erdy)
            3'b001:  pend_pkt = pkt[0];
            3'b010:  pend_pkt = pkt[1];
            3'b100:  pend_pkt = pkt[2];
            default: pend_pkt = '0;
        endcase
    endtask

    task automatic reset_and_check();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        req_valid   = 3'b111;
        cur_exp_rdy = 3'b000;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pkt", out_pkt, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_err_src", err_src, 0);
        chk("rst_round_done", round_done, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 3'b000;
        out_ready = 1'b1;
        mon_en    = 1'b1;
    endtask

    task automatic send_seq(input int i, input int n_psum, input bit filt, input int tag);
        for (int k = 0; k < n_psum; k++) begin
            pkt[i] = mk_pkt(i, 1'b0, tag + k);
            drive(3'(1 << i), 1'b1, 3'(1 << i));
        end
        if (filt) begin
            pkt[i] = mk_pkt(i, 1'b1, tag + 8);
            drive(3'(1 << i), 1'b1, 3'(1 << i));
        end
    endtask

    // ---------------- scoreboard ----------------
    // Queue holds the packets the output register should contain after each edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (mon_en) begin
            chk("req_ready", req_ready, cur_exp_rdy);
            chk("out_valid", out_valid, 64'(exp_q.size() != 0));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_pkt act=%0h exp=none", out_pkt);
                end else begin
                    chk("out_pkt", out_pkt, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (cur_exp_rdy != 3'b000) exp_q.push_back(pend_pkt);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] valid;
        logic       ordy;
        logic [2:0] filt;
        logic [2:0] erdy;
    } vec_t;

    vec_t tbl[17];
    int   sent[3];

    initial begin
        rst_n       = 1'b1;
        req_valid   = 3'b000;
        out_ready   = 1'b1;
        req_pkt     = '0;
        cur_exp_rdy = 3'b000;
        pend_pkt    = '0;
        mon_en      = 1'b0;
        for (int i = 0; i < 3; i++) pkt[i] = mk_pkt(i, 1'b0, 0);

        tbl[0]  = '{3'b111, 1'b1, 3'b000, 3'b001};
        tbl[1]  = '{3'b111, 1'b1, 3'b000, 3'b010};
        tbl[2]  = '{3'b111, 1'b1, 3'b000, 3'b100};
        tbl[3]  = '{3'b111, 1'b1, 3'b000, 3'b001};
        tbl[4]  = '{3'b111, 1'b1, 3'b000, 3'b010};
        tbl[5]  = '{3'b111, 1'b1, 3'b000, 3'b100};
        tbl[6]  = '{3'b000, 1'b1, 3'b000, 3'b000};
        tbl[7]  = '{3'b010, 1'b1, 3'b000, 3'b010};
        tbl[8]  = '{3'b000, 1'b0, 3'b000, 3'b000};
        tbl[9]  = '{3'b110, 1'b0, 3'b000, 3'b000};
        tbl[10] = '{3'b010, 1'b0, 3'b000, 3'b000};
        tbl[11] = '{3'b010, 1'b0, 3'b000, 3'b000};
        tbl[12] = '{3'b010, 1'b0, 3'b000, 3'b000};
        tbl[13] = '{3'b010, 1'b1, 3'b010, 3'b010};
        tbl[14] = '{3'b101, 1'b1, 3'b000, 3'b100};
        tbl[15] = '{3'b001, 1'b1, 3'b000, 3'b001};
        tbl[16] = '{3'b000, 1'b1, 3'b000, 3'b000};

        reset_and_check();

        // Fill the output register, stall it, then reset with a packet in flight.
        drive(3'b111, 1'b0, 3'b001);
        drive(3'b111, 1'b0, 3'b000);
        reset_and_check();

        // Arbitration, throughput and backpressure vectors.
        for (int r = 0; r < 17; r++) begin
            for (int i = 0; i < 3; i++) pkt[i] = mk_pkt(i, tbl[r].filt[i], r);
            drive(tbl[r].valid, tbl[r].ordy, tbl[r].erdy);
        end
        @(negedge clk);
        chk("tbl_proto_err", proto_err, 0);
        chk("tbl_round_done", round_done, 0);

        // Legal round: three psums then a filter from every PE, all contending.
        reset_and_check();
        for (int i = 0; i < 3; i++) sent[i] = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 12) begin
                for (int i = 0; i < 3; i++) pkt[i] = mk_pkt(i, sent[i] >= 3, 20 + c);
                drive(3'b111, 1'b1, 3'(1 << (c % 3)));
                sent[c % 3]++;
            end else begin
                drive(3'b000, 1'b1, 3'b000);
            end
            @(negedge clk);
            chk($sformatf("round_done_c%0d", c), round_done, 64'(c == 12));
        end
        chk("round_proto_err", proto_err, 0);

        // Early filter from req 2, then a bad dest from req 0.
        reset_and_check();
        send_seq(2, 1, 1'b0, 40);
        pkt[2] = mk_pkt(2, 1'b1, 41);
        drive(3'b100, 1'b1, 3'b100);
        @(negedge clk);
        chk("viol_before", proto_err, 0);
        pkt[0] = mk_pkt(0, 1'b0, 42);
        pkt[0][45:43] = 3'd5;
        drive(3'b001, 1'b1, 3'b001);
        @(negedge clk);
        chk("viol_proto_err", proto_err, 1);
        chk("viol_err_src", err_src, 2);
        drive(3'b000, 1'b1, 3'b000);
        @(negedge clk);
        chk("viol2_proto_err", proto_err, 1);
        chk("viol2_err_src", err_src, 2);

        // Wrong src from req 1 still advances its counter: the round must complete.
        reset_and_check();
        pkt[1] = mk_pkt(1, 1'b0, 50);
        pkt[1][42:40] = 3'd3;
        drive(3'b010, 1'b1, 3'b010);
        pkt[1] = mk_pkt(1, 1'b0, 51);
        drive(3'b010, 1'b1, 3'b010);
        @(negedge clk);
        chk("src_proto_err", proto_err, 1);
        chk("src_err_src", err_src, 1);
        send_seq(1, 1, 1'b1, 52);
        send_seq(0, 3, 1'b1, 60);
        send_seq(2, 3, 1'b1, 70);
        drive(3'b000, 1'b1, 3'b000);
        @(negedge clk);
        chk("src_round_done", round_done, 1);
        chk("src_err_src_hold", err_src, 1);
        drive(3'b000, 1'b1, 3'b000);
        @(negedge clk);
        chk("src_round_done_pulse", round_done, 0);
        chk("final_queue_empty", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
